// File: rtl/lab3_cache_mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory port between two caches.
// A small ID FIFO remembers who issued each request so in-order responses route back.
module lab3_cache_mem_arbiter #(
  parameter int p_max_inflight = 4,
  parameter int p_req_nbits    = 77,
  parameter int p_resp_nbits   = 47
) (
  input  logic                              clk,
  input  logic                              reset,

  input  logic                              req0_val,
  output logic                              req0_rdy,
  input  logic [p_req_nbits-1:0]            req0_msg,
  input  logic                              req1_val,
  output logic                              req1_rdy,
  input  logic [p_req_nbits-1:0]            req1_msg,

  output logic                              resp0_val,
  input  logic                              resp0_rdy,
  output logic [p_resp_nbits-1:0]           resp0_msg,
  output logic                              resp1_val,
  input  logic                              resp1_rdy,
  output logic [p_resp_nbits-1:0]           resp1_msg,

  output logic                              mem_req_val,
  input  logic                              mem_req_rdy,
  output logic [p_req_nbits-1:0]            mem_req_msg,
  input  logic                              mem_resp_val,
  output logic                              mem_resp_rdy,
  input  logic [p_resp_nbits-1:0]           mem_resp_msg,

  output logic [$clog2(p_max_inflight):0]   inflight
);

  localparam int c_ptr_nbits = $clog2(p_max_inflight);
  localparam int c_cnt_nbits = c_ptr_nbits + 1;
  localparam logic [c_cnt_nbits-1:0] c_full_count = c_cnt_nbits'(p_max_inflight);

  logic                   prio_reg, prio_next;
  logic [c_ptr_nbits-1:0] head_ptr_reg, head_ptr_next;
  logic [c_ptr_nbits-1:0] tail_ptr_reg, tail_ptr_next;
  logic [c_cnt_nbits-1:0] count_reg, count_next;
  logic [p_max_inflight-1:0] id_vec;

  logic full, empty;
  logic grant_val, grant_id;
  logic req_fire, resp_fire;
  logic head_id;

  assign full  = (count_reg == c_full_count);
  assign empty = (count_reg == '0);

  // Both valid: the pointer decides; otherwise the lone valid requester wins.
  always_comb begin
    grant_val = req0_val | req1_val;
    grant_id  = 1'b0;
    if (req0_val && req1_val) grant_id = prio_reg;
    else if (req1_val)        grant_id = 1'b1;
  end

  assign mem_req_val = reset & grant_val & ~full;
  assign mem_req_msg = grant_id ? req1_msg : req0_msg;
  assign req0_rdy    = reset & grant_val & ~grant_id & mem_req_rdy & ~full;
  assign req1_rdy    = reset & grant_val &  grant_id & mem_req_rdy & ~full;
  assign req_fire    = mem_req_val & mem_req_rdy;

  assign head_id      = id_vec[head_ptr_reg];
  assign resp0_val    = reset & mem_resp_val & ~empty & ~head_id;
  assign resp1_val    = reset & mem_resp_val & ~empty &  head_id;
  assign resp0_msg    = mem_resp_msg;
  assign resp1_msg    = mem_resp_msg;
  assign mem_resp_rdy = reset & ~empty & (head_id ? resp1_rdy : resp0_rdy);
  assign resp_fire    = mem_resp_val & mem_resp_rdy;

  always_comb begin
    prio_next     = prio_reg;
    head_ptr_next = head_ptr_reg;
    tail_ptr_next = tail_ptr_reg;
    count_next    = count_reg;
    if (req_fire) begin
      prio_next     = ~grant_id;
      tail_ptr_next = tail_ptr_reg + 1'b1;
    end
    if (resp_fire) head_ptr_next = head_ptr_reg + 1'b1;
    if (req_fire && !resp_fire)      count_next = count_reg + 1'b1;
    else if (!req_fire && resp_fire) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_reg     <= 1'b0;
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      prio_reg     <= prio_next;
      head_ptr_reg <= head_ptr_next;
      tail_ptr_reg <= tail_ptr_next;
      count_reg    <= count_next;
    end
  end

  // One flop per FIFO slot; the tail pointer selects which slot captures the grant.
  genvar gi;
  generate
    for (gi = 0; gi < p_max_inflight; gi++) begin : g_id_slot
      localparam logic [c_ptr_nbits-1:0] c_idx = c_ptr_nbits'(gi);
      logic slot_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            slot_reg <= 1'b0;
        else if (req_fire && tail_ptr_reg == c_idx) slot_reg <= grant_id;
      end

      assign id_vec[gi] = slot_reg;
    end
  endgenerate

  assign inflight = count_reg;

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Directed bench for lab3_cache_mem_arbiter with a queue-based reference model
// checked on every falling edge, plus literal expectations at key points.
module tb_lab3_cache_mem_arbiter;

  localparam int P     = 4;
  localparam int REQW  = 77;
  localparam int RESPW = 47;

  logic clk, reset;
  logic req0_val, req0_rdy, req1_val, req1_rdy;
  logic [REQW-1:0] req0_msg, req1_msg, mem_req_msg;
  logic resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [RESPW-1:0] resp0_msg, resp1_msg, mem_resp_msg;
  logic mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  logic [$clog2(P):0] inflight;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outstanding requester IDs in issue order, plus priority.
  bit id_q[$];
  bit m_prio;

  lab3_cache_mem_arbiter #(.p_max_inflight(P), .p_req_nbits(REQW), .p_resp_nbits(RESPW)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [REQW-1:0] mk_req(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] data);
    return {3'd0, op, addr, 2'd0, data};
  endfunction

  function automatic logic [RESPW-1:0] mk_resp(input logic [7:0] op, input logic [31:0] data);
    return {3'd0, op, 2'd0, 2'd0, data};
  endfunction

  // Per-cycle compare against the model, then advance the model across the next rising edge.
  always @(negedge clk) begin
    bit anyv, g, room, has, head, e_req_fire, e_resp_fire;
    if (!reset) begin
      chk("rst_mem_req_val", mem_req_val, 0);
      chk("rst_req0_rdy", req0_rdy, 0);
      chk("rst_req1_rdy", req1_rdy, 0);
      chk("rst_resp0_val", resp0_val, 0);
      chk("rst_resp1_val", resp1_val, 0);
      chk("rst_mem_resp_rdy", mem_resp_rdy, 0);
      chk("rst_inflight", inflight, 0);
      id_q.delete();
      m_prio = 1'b0;
    end else begin
      anyv = req0_val | req1_val;
      g    = (req0_val && req1_val) ? m_prio : req1_val;
      room = (id_q.size() < P);
      has  = (id_q.size() > 0);
      head = has ? id_q[0] : 1'b0;

      chk("mem_req_val", mem_req_val, anyv && room);
      chk("req0_rdy", req0_rdy, anyv && !g && mem_req_rdy && room);
      chk("req1_rdy", req1_rdy, anyv && g && mem_req_rdy && room);
      if (mem_req_val) chk("mem_req_msg", mem_req_msg, g ? req1_msg : req0_msg);
      chk("resp0_val", resp0_val, mem_resp_val && has && !head);
      chk("resp1_val", resp1_val, mem_resp_val && has && head);
      chk("mem_resp_rdy", mem_resp_rdy, has && (head ? resp1_rdy : resp0_rdy));
      if (resp0_val) chk("resp0_msg", resp0_msg, mem_resp_msg);
      if (resp1_val) chk("resp1_msg", resp1_msg, mem_resp_msg);
      chk("inflight", inflight, id_q.size());

      e_req_fire  = anyv && room && mem_req_rdy;
      e_resp_fire = has && mem_resp_val && (head ? resp1_rdy : resp0_rdy);
      if (e_resp_fire) begin
        $display("resp id=%0d data=%h", head, mem_resp_msg[31:0]);
        void'(id_q.pop_front());
      end
      if (e_req_fire) begin
        $display("req  id=%0d addr=%h", g, g ? req1_msg[65:34] : req0_msg[65:34]);
        id_q.push_back(g);
        m_prio = !g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
    resp0_rdy = 1; resp1_rdy = 1; mem_req_rdy = 1;
    mem_resp_val = 0; mem_resp_msg = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    step();
    step();
    reset = 1;
  endtask

  logic [REQW-1:0] req_a, req_b;

  initial begin
    reset = 0;
    clear_inputs();
    req0_val = 1;
    #2;
    chk("init_mem_req_val", mem_req_val, 0);
    chk("init_inflight", inflight, 0);
    do_reset();

    // Single requester read, response routed to port 0
    req0_val = 1; req0_msg = mk_req(8'h01, 32'h1000, 32'h0);
    #1;
    chk("t1_req0_rdy", req0_rdy, 1);
    chk("t1_addr", mem_req_msg[65:34], 32'h1000);
    step();
    req0_val = 0;
    #1 chk("t1_inflight1", inflight, 1);
    mem_resp_val = 1; mem_resp_msg = mk_resp(8'h01, 32'hdeadbeef);
    #1;
    chk("t1_resp0_val", resp0_val, 1);
    chk("t1_resp1_val", resp1_val, 0);
    chk("t1_data", resp0_msg[31:0], 32'hdeadbeef);
    step();
    mem_resp_val = 0;
    #1 chk("t1_inflight0", inflight, 0);

    // Contention from reset, then full stall
    do_reset();
    req0_val = 1; req1_val = 1;
    req0_msg = mk_req(8'h10, 32'h2000, 32'h0);
    req1_msg = mk_req(8'h20, 32'h3000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_req0_rdy", req0_rdy, (k % 2) == 0);
      chk("t2_req1_rdy", req1_rdy, (k % 2) == 1);
      chk("t2_inflight", inflight, k);
      step();
    end
    #1;
    chk("t3_full_val", mem_req_val, 0);
    chk("t3_full_rdy0", req0_rdy, 0);
    chk("t3_full_rdy1", req1_rdy, 0);
    chk("t3_full_inflight", inflight, 4);
    mem_resp_val = 1; mem_resp_msg = mk_resp(8'h10, 32'h0a);
    #1;
    chk("t3_pop_resp0", resp0_val, 1);
    chk("t3_no_bypass", mem_req_val, 0);
    step();
    mem_resp_val = 0;
    #1;
    chk("t3_after_pop_inflight", inflight, 3);
    chk("t3_after_pop_val", mem_req_val, 1);
    chk("t3_after_pop_rdy0", req0_rdy, 1);
    step();
    req0_val = 0; req1_val = 0;
    #1 chk("t3_refull", inflight, 4);
    for (int k = 0; k < 4; k++) begin
      mem_resp_val = 1; mem_resp_msg = mk_resp(8'h30, 32'h100 + k);
      step();
    end
    mem_resp_val = 0;
    #1 chk("t3_drained", inflight, 0);

    // Response routing with issue order 1,0,1
    req1_val = 1; req1_msg = mk_req(8'h41, 32'h4100, 32'h0);
    step();
    req1_val = 0; req0_val = 1; req0_msg = mk_req(8'h42, 32'h4200, 32'h0);
    step();
    req0_val = 0; req1_val = 1; req1_msg = mk_req(8'h43, 32'h4300, 32'h0);
    step();
    req1_val = 0;
    #1 chk("t4_inflight", inflight, 3);
    mem_resp_val = 1; mem_resp_msg = mk_resp(8'h41, 32'h11); resp1_rdy = 0;
    #1;
    chk("t4_hold_val1", resp1_val, 1);
    chk("t4_hold_rdy", mem_resp_rdy, 0);
    step();
    #1 chk("t4_hold_rdy2", mem_resp_rdy, 0);
    resp1_rdy = 1;
    #1;
    chk("t4_rel_rdy", mem_resp_rdy, 1);
    chk("t4_data11", resp1_msg[31:0], 32'h11);
    step();
    mem_resp_msg = mk_resp(8'h42, 32'h22);
    #1;
    chk("t4_val0", resp0_val, 1);
    chk("t4_val1_off", resp1_val, 0);
    chk("t4_data22", resp0_msg[31:0], 32'h22);
    step();
    mem_resp_msg = mk_resp(8'h43, 32'h33);
    #1;
    chk("t4_val1", resp1_val, 1);
    chk("t4_data33", resp1_msg[31:0], 32'h33);
    step();
    mem_resp_val = 0;
    #1 chk("t4_inflight0", inflight, 0);

    // Backpressure: last fire was port 1, so port 0 holds priority
    req_a = mk_req(8'h50, 32'ha000, 32'h0);
    req_b = mk_req(8'h51, 32'hb000, 32'h0);
    req0_val = 1; req1_val = 1; req0_msg = req_a; req1_msg = req_b; mem_req_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_bp_val", mem_req_val, 1);
      chk("t5_bp_rdy0", req0_rdy, 0);
      chk("t5_bp_msg", mem_req_msg, req_a);
      chk("t5_bp_inflight", inflight, 0);
      step();
    end
    mem_req_rdy = 1;
    #1;
    chk("t5_rel_rdy0", req0_rdy, 1);
    chk("t5_rel_rdy1", req1_rdy, 0);
    step();
    #1;
    chk("t5_next_rdy1", req1_rdy, 1);
    step();
    #1 chk("t6_inflight2", inflight, 2);

    // Asynchronous reset mid-cycle with two requests outstanding
    #1 reset = 0;
    #1;
    chk("t6_async_val", mem_req_val, 0);
    chk("t6_async_rdy0", req0_rdy, 0);
    chk("t6_async_inflight", inflight, 0);
    step();
    step();
    clear_inputs();
    reset = 1;
    mem_resp_val = 1; mem_resp_msg = mk_resp(8'h60, 32'h66);
    #1;
    chk("t6_stray_rdy", mem_resp_rdy, 0);
    chk("t6_stray_val0", resp0_val, 0);
    chk("t6_stray_val1", resp1_val, 0);
    step();
    #1 chk("t6_stray_rdy2", mem_resp_rdy, 0);
    mem_resp_val = 0;
    req0_val = 1; req1_val = 1;
    #1;
    chk("t6_prio_rdy0", req0_rdy, 1);
    chk("t6_prio_rdy1", req1_rdy, 0);
    step();
    req0_val = 0; req1_val = 0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
